// File: rtl/ub_row_feeder.sv
// Streams consecutive unified-buffer rows into the systolic array edge,
// tracking the buffer's 3-cycle read latency and skewing lane i by i cycles.
module ub_row_feeder #(
    parameter int MATRIX_WIDTH = 14,
    parameter int ROWS_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDR_WIDTH-1:0]        cmd_addr,
    input  logic [ROWS_WIDTH-1:0]        cmd_rows,
    output logic [ADDR_WIDTH-1:0]        ub_addr0,
    output logic                         ub_en0,
    input  logic [MATRIX_WIDTH-1:0][7:0] ub_read_port0,
    output logic [MATRIX_WIDTH-1:0][7:0] sys_data,
    output logic [MATRIX_WIDTH-1:0]      sys_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int MW = MATRIX_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [ROWS_WIDTH-1:0]   rows_reg;
    logic                    ready_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [2:0]              lat_v_reg;
    // skew_v_reg[j] is the read-valid bit delayed j+1 more cycles; it is lane j+1's valid
    logic [MW-2:0]           skew_v_reg;
    logic                    issue;
    logic                    drain_empty;

    assign issue       = (state_reg == ISSUE) && enable;
    // Empty after the next shift: only the last skew stage may still hold data
    assign drain_empty = (lat_v_reg == 3'b000) && (skew_v_reg[MW-3:0] == '0);

    assign ub_en0    = issue;
    assign ub_addr0  = addr_reg;
    assign cmd_ready = ready_reg && enable;
    assign busy      = busy_reg;
    assign done      = done_reg && enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            rows_reg   <= '0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            lat_v_reg  <= '0;
            skew_v_reg <= '0;
        end else if (enable) begin
            lat_v_reg  <= {lat_v_reg[1:0], issue};
            skew_v_reg <= {skew_v_reg[MW-3:0], lat_v_reg[2]};
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_reg  <= cmd_addr;
                        rows_reg  <= cmd_rows;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        if (cmd_rows == '0) begin
                            // Nothing in flight, so completion is immediate
                            state_reg <= DRAIN;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    addr_reg <= addr_reg + ADDR_WIDTH'(1);
                    rows_reg <= rows_reg - ROWS_WIDTH'(1);
                    if (rows_reg == ROWS_WIDTH'(1)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done_reg) begin
                        done_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (drain_empty) begin
                        done_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Lane 0 needs no delay: the buffer's output register is its only stage
    assign sys_valid[0] = lat_v_reg[2];
    assign sys_data[0]  = lat_v_reg[2] ? ub_read_port0[0] : 8'h00;

    generate
        for (genvar gi = 1; gi < MW; gi++) begin : g_lane
            logic [gi-1:0][7:0] stage_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= '0;
                end else if (enable) begin
                    stage_reg[0] <= ub_read_port0[gi];
                    for (int j = 1; j < gi; j++) begin
                        stage_reg[j] <= stage_reg[j-1];
                    end
                end
            end

            assign sys_valid[gi] = skew_v_reg[gi-1];
            assign sys_data[gi]  = skew_v_reg[gi-1] ? stage_reg[gi-1] : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_ub_row_feeder.sv
// Scoreboard bench for ub_row_feeder: stimulus pushes expected issues, lane bytes
// and done cycles; a negedge monitor pops and compares whatever the DUT presents.
module tb_ub_row_feeder;

    localparam int MW = 14;
    localparam int RW = 16;
    localparam int AW = 24;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [AW-1:0]       cmd_addr = '0;
    logic [RW-1:0]       cmd_rows = '0;
    logic [AW-1:0]       ub_addr0;
    logic                ub_en0;
    logic [MW-1:0][7:0]  ub_read_port0 = '0;
    logic [MW-1:0][7:0]  sys_data;
    logic [MW-1:0]       sys_valid;
    logic                busy;
    logic                done;

    ub_row_feeder #(.MATRIX_WIDTH(MW), .ROWS_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rows(cmd_rows),
        .ub_addr0(ub_addr0), .ub_en0(ub_en0), .ub_read_port0(ub_read_port0),
        .sys_data(sys_data), .sys_valid(sys_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Preloaded buffer contents: rows 0, 8 and 9 hold the hand-picked test rows
    function automatic logic [7:0] ub_byte(input logic [AW-1:0] a, input int i);
        case (a)
            24'h000000: return 8'h7F - 8'(i);
            24'h000008: return 8'h0F + 8'(i);
            24'h000009: return 8'h01 + 8'(i);
            default:    return {a[3:0], 4'(i)} ^ 8'hA5;
        endcase
    endfunction

    // Unified buffer model: 3-cycle read latency, stalled by enable
    logic [MW-1:0][7:0] ub_s0 = '0;
    logic [MW-1:0][7:0] ub_s1 = '0;
    always @(posedge clk) begin
        if (enable) begin
            if (ub_en0) begin
                for (int i = 0; i < MW; i++) ub_s0[i] <= ub_byte(ub_addr0, i);
            end
            ub_s1         <= ub_s0;
            ub_read_port0 <= ub_s1;
        end
    end

    typedef struct { logic [7:0] d; int c; } lane_exp_t;
    typedef struct { logic [AW-1:0] a; int c; } addr_exp_t;

    lane_exp_t lane_q[MW][$];
    addr_exp_t addr_q[$];
    int        done_q[$];

    int checks = 0;
    int fails = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [127:0] act);
        checks++;
        fails++;
        $display("FAIL %s: cycle %0d got %0h required nothing", name, cyc, act);
    endtask

    // Monitor: only cycles with enable=1 count as presented transfers
    addr_exp_t ea;
    lane_exp_t el;
    int        ed;
    always @(negedge clk) begin
        if (!rst && done && !enable) flag("done_while_stalled", done);
        if (!rst && enable) begin
            if (ub_en0) begin
                if (addr_q.size() == 0) flag("unexpected_issue", ub_addr0);
                else begin
                    ea = addr_q.pop_front();
                    chk("ub_addr0", ub_addr0, ea.a);
                    chk("issue_cycle", cyc, ea.c);
                    $display("issue addr=%06h cycle=%0d", ub_addr0, cyc);
                end
            end
            for (int i = 0; i < MW; i++) begin
                if (sys_valid[i]) begin
                    if (lane_q[i].size() == 0) flag($sformatf("unexpected_lane%0d", i), sys_data[i]);
                    else begin
                        el = lane_q[i].pop_front();
                        chk($sformatf("lane%0d_data", i), sys_data[i], el.d);
                        if (el.c >= 0) chk($sformatf("lane%0d_cycle", i), cyc, el.c);
                    end
                end else begin
                    chk($sformatf("lane%0d_idle_zero", i), sys_data[i], 8'h00);
                end
            end
            if (done) begin
                done_seen++;
                if (done_q.size() == 0) flag("unexpected_done", done);
                else begin
                    ed = done_q.pop_front();
                    chk("done_cycle", cyc, ed);
                    $display("done cycle=%0d", cyc);
                end
            end
        end
    end

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (done_seen == start && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_seen == start) flag("done_timeout", n);
    endtask

    task automatic push_cmd(input logic [AW-1:0] addr, input int rows, input int a, input bit stall);
        logic [AW-1:0] ak;
        int sh;
        sh = stall ? 3 : 0;
        for (int k = 0; k < rows; k++) begin
            ak = addr + AW'(k);
            addr_q.push_back('{ak, a + 1 + k + ((stall && k >= 2) ? 3 : 0)});
            for (int i = 0; i < MW; i++) lane_q[i].push_back('{ub_byte(ak, i), a + 4 + k + i + sh});
        end
        done_q.push_back(rows == 0 ? a + 1 : a + 1 + rows + MW + 2 + sh);
    endtask

    task automatic run_cmd(input logic [AW-1:0] addr, input int rows, input bit stall);
        int a;
        int start;
        start = done_seen;
        @(posedge clk); #1;
        a = cyc;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_rows  = RW'(rows);
        push_cmd(addr, rows, a, stall);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
        if (rows == 0) begin
            @(posedge clk); #1;
            chk("cmd_ready_after_zero", cmd_ready, 1'b1);
            chk("busy_after_zero", busy, 1'b0);
        end
        if (stall) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            enable = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            enable = 1'b1;
        end
        wait_done(start);
        chk("idle_after_done", cmd_ready, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_ub_en0"}, ub_en0, 1'b0);
        chk({tag, "_ub_addr0"}, ub_addr0, '0);
        chk({tag, "_sys_data"}, sys_data, '0);
        chk({tag, "_sys_valid"}, sys_valid, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        int a;
        int start;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outputs("reset");

        run_cmd(24'h000000, 1, 1'b0);
        run_cmd(24'h000008, 2, 1'b0);
        run_cmd(24'h000040, 0, 1'b0);
        run_cmd(24'h000030, 4, 1'b1);

        // Reset in the middle of issuing row 2 of 5
        @(posedge clk); #1;
        a = cyc;
        cmd_valid = 1'b1; cmd_addr = 24'h000020; cmd_rows = RW'(5);
        addr_q.push_back('{24'h000020, a + 1});
        addr_q.push_back('{24'h000021, a + 2});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("midreset");
        repeat (20) @(posedge clk);
        run_cmd(24'h000009, 3, 1'b0);

        // cmd_valid held through busy; address wraps at the top of the space
        start = done_seen;
        @(posedge clk); #1;
        a = cyc;
        cmd_valid = 1'b1; cmd_addr = 24'hFFFFFF; cmd_rows = RW'(2);
        push_cmd(24'hFFFFFF, 2, a, 1'b0);
        @(posedge clk); #1;
        chk("hold_cmd_ready", cmd_ready, 1'b0);
        wait_done(start);
        cmd_valid = 1'b0;

        repeat (25) @(posedge clk);
        #1;
        chk("addr_q_empty", addr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        for (int i = 0; i < MW; i++) chk($sformatf("lane%0d_q_empty", i), lane_q[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
